fetch_stage: RTL and testbench

Instruction fetch stage of the 5-stage RISC-V pipeline, directly upstream of the decode stage. Owns the program counter, issues word fetches to instruction memory over a single-outstanding request/response handshake, and drives the IF/ID pipeline register (`instruction`, `pc`) consumed by decode. Obeys decode's stall (`PCWrite`, `FetchWrite`) and redirect (`PCSrc`, `pc_branch`, `IF_Flush`) outputs, and discards in-flight fetches made stale by a taken branch.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle for fetch_stage.
// Single outstanding request: imem_req strobes one cycle, imem_ready strobes with the data.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V IF stage: owns the PC, fetches words over fetch_stage_if, drives the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
//
// state   | meaning
// IDLE    | just out of reset, first fetch next cycle
// FETCH   | ready to issue a request at pc_reg
// WAIT    | request outstanding, waiting for imem_ready
// HOLD    | response captured in hold_buf, IF/ID stalled by FetchWrite
// DISCARD | outstanding response is stale after a redirect, drop it
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        FetchWrite,
  input  logic        PCSrc,
  input  logic [31:0] pc_branch,
  input  logic        IF_Flush,
  fetch_stage_if.master imem,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_reg_q, pc_reg_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, if_pc_q;
  logic        valid_q;
  logic        load;
  logic [31:0] load_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_reg_q <= RESET_PC;
      hold_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_reg_q <= pc_reg_d;
      hold_q   <= hold_d;
    end
  end

  // A request is never issued alongside a redirect: the FSM leaves for FETCH
  // and would lose track of a response to the old address.
  always_comb begin
    state_d       = state_q;
    pc_reg_d      = pc_reg_q;
    hold_d        = hold_q;
    load          = 1'b0;
    load_word     = imem.imem_rdata;
    imem.imem_req = 1'b0;
    if (PCSrc) begin
      pc_reg_d = pc_branch;
      state_d  = (state_q == S_WAIT && !imem.imem_ready) ? S_DISCARD : S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (PCWrite) begin
            imem.imem_req = 1'b1;
            state_d       = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_ready) begin
            if (FetchWrite) begin
              load     = 1'b1;
              pc_reg_d = pc_reg_q + 32'd4;
              state_d  = S_FETCH;
            end else begin
              hold_d  = imem.imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (FetchWrite) begin
            load      = 1'b1;
            load_word = hold_q;
            pc_reg_d  = pc_reg_q + 32'd4;
            state_d   = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem.imem_ready) state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imem.imem_addr = pc_reg_q;

  // Flush wins over a same-cycle load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP_INSTR;
      if_pc_q <= RESET_PC;
      valid_q <= 1'b0;
    end else if (IF_Flush) begin
      instr_q <= NOP_INSTR;
      if_pc_q <= pc_reg_q;
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= load_word;
      if_pc_q <= pc_reg_q;
      valid_q <= 1'b1;
    end
  end

  assign instruction = instr_q;
  assign pc          = if_pc_q;
  assign instr_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, flushed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= 32'h0;
      flushed_q <= 32'h0;
    end else begin
      if (load && !IF_Flush) fetched_q <= fetched_q + 32'd1;
      if (IF_Flush)          flushed_q <= flushed_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model and a latency-programmable memory.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        pc_write, fetch_write, pc_src, if_flush;
  logic [31:0] pc_branch;
  logic [31:0] instruction, pc;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .PCWrite     (pc_write),
    .FetchWrite  (fetch_write),
    .PCSrc       (pc_src),
    .pc_branch   (pc_branch),
    .IF_Flush    (if_flush),
    .imem        (imem_bus),
    .instruction (instruction),
    .pc          (pc),
    .instr_valid (instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_pc;
  bit          m_idle, m_out, m_stale, m_held;
  logic [31:0] m_hold_w;
  logic [31:0] e_instr, e_pc, e_fetched, e_flushed;
  logic        e_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_idle = 1; m_out = 0; m_stale = 0; m_held = 0; m_hold_w = 32'h0;
    e_instr = 32'h13; e_pc = 32'h0; e_valid = 0; e_fetched = 32'h0; e_flushed = 32'h0;
  endtask

  function automatic bit model_req();
    return rst_n && !m_idle && !m_out && !m_stale && !m_held && pc_write && !pc_src;
  endfunction

  task automatic model_update();
    bit          ld;
    logic [31:0] ld_w, nxt_pc;
    bit          rq;
    ld = 0; ld_w = 32'h0; nxt_pc = m_pc; rq = model_req();
    if (pc_src) begin
      nxt_pc  = pc_branch;
      m_stale = m_out && !imem_bus.imem_ready;
      m_out   = 0;
      m_held  = 0;
    end else if (m_out && imem_bus.imem_ready) begin
      m_out = 0;
      if (fetch_write) begin
        ld = 1; ld_w = imem_bus.imem_rdata; nxt_pc = m_pc + 32'd4;
      end else begin
        m_held = 1; m_hold_w = imem_bus.imem_rdata;
      end
    end else if (m_stale && imem_bus.imem_ready) begin
      m_stale = 0;
    end else if (m_held && fetch_write) begin
      ld = 1; ld_w = m_hold_w; m_held = 0; nxt_pc = m_pc + 32'd4;
    end else if (rq) begin
      m_out = 1;
    end
    m_idle = 0;
    if (if_flush) begin
      e_instr = 32'h13; e_pc = m_pc; e_valid = 0; e_flushed = e_flushed + 32'd1;
    end else if (ld) begin
      e_instr = ld_w; e_pc = m_pc; e_valid = 1; e_fetched = e_fetched + 32'd1;
    end
    m_pc = nxt_pc;
  endtask

  // ---------------- memory model ----------------
  bit          mem_pend, spur_en;
  int          mem_wait, mem_lat;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h0001_0DCD) ^ 32'h3C3C_0F0F;
  endfunction

  task automatic mem_clear();
    mem_pend = 0; mem_wait = 0; mem_addr = 32'h0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
  endtask

  task automatic mem_step(input bit rq, input logic [31:0] ra);
    if (mem_pend) begin
      if (mem_wait == 0) mem_pend = 0;
      else mem_wait--;
    end
    if (rq) begin
      mem_pend = 1; mem_wait = mem_lat - 1; mem_addr = ra;
    end
  endtask

  task automatic mem_drive();
    if (mem_pend && mem_wait == 0) begin
      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = mem_word(mem_addr);
    end else begin
      imem_bus.imem_ready = spur_en && ($urandom_range(0, 7) == 0);
      imem_bus.imem_rdata = $urandom;
    end
  endtask

  task automatic tick();
    bit          rq;
    logic [31:0] ra;
    @(posedge clk);
    rq = model_req();
    ra = m_pc;
    if (rst_n) model_update();
    mem_step(rq, ra);
    #1;
    mem_drive();
  endtask

  // ---------------- per-cycle compare ----------------
  bit exp_req_c;
  always @(negedge clk) begin
    exp_req_c = model_req();
    chk("req", 32'(imem_bus.imem_req), 32'(exp_req_c));
    if (exp_req_c) chk("addr", imem_bus.imem_addr, m_pc);
    chk("instruction", instruction, e_instr);
    chk("pc", pc, e_pc);
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, e_fetched);
    chk("perf_flushed", perf_flushed, e_flushed);
`endif
  end

  task automatic chk_ifid(input string name, input logic [31:0] ei, input logic [31:0] ep,
                          input logic ev);
    chk({name, "_instr"}, instruction, ei);
    chk({name, "_pc"}, pc, ep);
    chk({name, "_valid"}, 32'(instr_valid), 32'(ev));
  endtask

  task automatic chk_req(input string name, input logic er, input logic [31:0] ea);
    chk({name, "_req"}, 32'(imem_bus.imem_req), 32'(er));
    if (er) chk({name, "_addr"}, imem_bus.imem_addr, ea);
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b1; fetch_write = 1'b1; pc_src = 1'b0; if_flush = 1'b0;
    pc_branch = 32'h0; spur_en = 0; mem_lat = 1;
    model_reset();
    mem_clear();
    repeat (2) tick();

    // reset values
    chk_ifid("rst", 32'h13, 32'h0, 1'b0);
    chk("rst_req", 32'(imem_bus.imem_req), 32'h0);
    chk("rst_addr", imem_bus.imem_addr, 32'h0);
    rst_n = 1'b1;

    // first two fetches, 1-cycle memory
    tick(); #1;
    chk_req("first", 1'b1, 32'h0);
    tick(); tick(); #1;
    chk_ifid("ld0", 32'h0050_0093, 32'h0, 1'b1);
    chk_req("ld0", 1'b1, 32'h4);
    tick(); tick(); #1;
    chk_ifid("ld4", 32'h0010_0113, 32'h4, 1'b1);
    chk_req("ld4", 1'b1, 32'h8);

    // FetchWrite low for 3 cycles while the word for 8 arrives
    fetch_write = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk_ifid("hold", 32'h0010_0113, 32'h4, 1'b1);
      chk_req("hold", 1'b0, 32'h0);
    end
    fetch_write = 1'b1;
    mem_lat = 3;
    tick(); #1;
    chk_ifid("rel", mem_word(32'h8), 32'h8, 1'b1);
    chk_req("rel", 1'b1, 32'hC);

    // redirect + flush one cycle into a 3-cycle WAIT
    tick();
    pc_src = 1'b1; if_flush = 1'b1; pc_branch = 32'h40;
    tick();
    pc_src = 1'b0; if_flush = 1'b0; #1;
    chk("flush_instr", instruction, 32'h13);
    chk("flush_valid", 32'(instr_valid), 32'h0);
    chk_req("disc1", 1'b0, 32'h0);
    tick(); #1;
    chk_req("disc2", 1'b0, 32'h0);
    tick(); #1;
    chk_req("redir", 1'b1, 32'h40);
    chk("stale_instr", instruction, 32'h13);
    repeat (4) tick();
    mem_lat = 1; #1;
    chk_ifid("tgt", mem_word(32'h40), 32'h40, 1'b1);
    chk_req("tgt", 1'b1, 32'h44);

    // redirect coincident with the response
    tick();
    pc_src = 1'b1; pc_branch = 32'h40;
    tick();
    pc_src = 1'b0; #1;
    chk_ifid("drop", mem_word(32'h40), 32'h40, 1'b1);
    chk_req("drop", 1'b1, 32'h40);

    // PCWrite stall in FETCH
    pc_write = 1'b0; #1;
    chk_req("stall1", 1'b0, 32'h0);
    tick(); #1;
    chk_req("stall2", 1'b0, 32'h0);
    tick();
    pc_write = 1'b1; mem_lat = 3; #1;
    chk_req("unstall", 1'b1, 32'h40);

    // reset mid-WAIT; the orphaned response must be ignored
    tick();
    pc_write = 1'b0; rst_n = 1'b0; model_reset(); #1;
    chk_ifid("mrst", 32'h13, 32'h0, 1'b0);
    chk("mrst_req", 32'(imem_bus.imem_req), 32'h0);
    chk("mrst_addr", imem_bus.imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    #1;
    chk_ifid("orphan", 32'h13, 32'h0, 1'b0);
    pc_write = 1'b1; #1;
    chk_req("post_rst", 1'b1, 32'h0);

    // PC wrap-around
    pc_src = 1'b1; pc_branch = 32'hFFFF_FFFC; mem_lat = 1; #1;
    chk_req("redir_noreq", 1'b0, 32'h0);
    tick();
    pc_src = 1'b0; #1;
    chk_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
    tick(); tick(); #1;
    chk_ifid("wrap", mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1);
    chk_req("wrap", 1'b1, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    // 5 fetches, 2 flushes from a clean reset
    rst_n = 1'b0; model_reset(); mem_clear();
    tick();
    rst_n = 1'b1;
    repeat (11) tick();
    pc_write = 1'b0; if_flush = 1'b1;
    repeat (2) tick();
    if_flush = 1'b0; #1;
    chk("perf_fetched_5", perf_fetched, 32'd5);
    chk("perf_flushed_2", perf_flushed, 32'd2);
`endif

    // randomized traffic
    spur_en = 1;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0; model_reset(); mem_clear();
      end else begin
        rst_n = 1'b1;
      end
      pc_write    = ($urandom_range(0, 3) != 0);
      fetch_write = ($urandom_range(0, 3) != 0);
      pc_src      = !m_stale && ($urandom_range(0, 9) == 0);
      pc_branch   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      if_flush    = ($urandom_range(0, 11) == 0);
      mem_lat     = $urandom_range(1, 4);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
